// File: rtl/sdram_arb_pkg.sv
// Shared types and width defaults for the SDRAM port arbiter family.
package sdram_arb_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_INIT = 3'd0,
    ST_ARB       = 3'd1,
    ST_WR        = 3'd2,
    ST_RD        = 3'd3,
    ST_DONE      = 3'd4
  } arb_state_t;

  localparam int NUM_PORTS_DEF = 2;
  localparam int ADDR_W_DEF    = 24;
  localparam int DATA_W_DEF    = 16;
  localparam int LEN_W_DEF     = 10;

endpackage

// File: rtl/sdram_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping.
module sdram_rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  always_comb begin : pick
    int p;
    valid = 1'b0;
    idx   = '0;
    p     = 0;
    // Walk offsets from farthest to nearest so the nearest requester is written last.
    for (int k = N - 1; k >= 0; k--) begin
      p = (int'(ptr) + k) % N;
      if (req[p]) begin
        valid = 1'b1;
        idx   = IDX_W'(p);
      end
    end
  end

endmodule

// File: rtl/sdram_port_arb.sv
// Round-robin arbiter granting whole sdram_ctrl bursts to one of NUM_PORTS clients.
module sdram_port_arb
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int LEN_W     = LEN_W_DEF
) (
  input  logic                        sdram_clk,
  input  logic                        sdram_rst_n,
  input  logic                        sdram_init_end,
  input  logic [NUM_PORTS-1:0]        port_req,
  input  logic [NUM_PORTS-1:0]        port_we,
  input  logic [NUM_PORTS*ADDR_W-1:0] port_addr,
  input  logic [NUM_PORTS*LEN_W-1:0]  port_bst_len,
  input  logic [NUM_PORTS*DATA_W-1:0] port_wr_data,
  output logic [NUM_PORTS-1:0]        port_wr_ack,
  output logic [NUM_PORTS-1:0]        port_rd_ack,
  output logic [DATA_W-1:0]           port_rd_data,
  output logic [NUM_PORTS-1:0]        port_done,
  output logic                        sdram_wr_req,
  output logic                        sdram_rd_req,
  output logic [ADDR_W-1:0]           sdram_wr_addr,
  output logic [ADDR_W-1:0]           sdram_rd_addr,
  output logic [LEN_W-1:0]            sdram_wr_bst_len,
  output logic [LEN_W-1:0]            sdram_rd_bst_len,
  output logic [DATA_W-1:0]           sdram_wr_data,
  input  logic                        sdram_wr_ack,
  input  logic                        sdram_rd_ack,
  input  logic [DATA_W-1:0]           sdram_rd_data
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  arb_state_t       state;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] rr_ptr;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic [ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0]  sel_len;
  logic              sel_we;

  sdram_rr_pick #(
    .N     (NUM_PORTS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (port_req),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign sel_addr = port_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
  assign sel_len  = port_bst_len[int'(pick_idx)*LEN_W +: LEN_W];
  assign sel_we   = port_we[pick_idx];

  assign sdram_wr_data = port_wr_data[int'(winner)*DATA_W +: DATA_W];
  assign port_rd_data  = sdram_rd_data;

  // Acks reach only the granted port and only while its burst is in flight.
  always_comb begin
    port_wr_ack = '0;
    port_rd_ack = '0;
    if (state == ST_WR) port_wr_ack[winner] = sdram_wr_ack;
    if (state == ST_RD) port_rd_ack[winner] = sdram_rd_ack;
  end

  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      state            <= ST_WAIT_INIT;
      winner           <= '0;
      rr_ptr           <= '0;
      len_q            <= '0;
      cnt              <= '0;
      port_done        <= '0;
      sdram_wr_req     <= 1'b0;
      sdram_rd_req     <= 1'b0;
      sdram_wr_addr    <= '0;
      sdram_rd_addr    <= '0;
      sdram_wr_bst_len <= '0;
      sdram_rd_bst_len <= '0;
    end else begin
      port_done <= '0;
      case (state)
        ST_WAIT_INIT: begin
          if (sdram_init_end) state <= ST_ARB;
        end
        ST_ARB: begin
          if (pick_valid) begin
            winner           <= pick_idx;
            len_q            <= sel_len;
            cnt              <= '0;
            sdram_wr_addr    <= '0;
            sdram_wr_bst_len <= '0;
            sdram_rd_addr    <= '0;
            sdram_rd_bst_len <= '0;
            if (sel_len == '0) begin
              state               <= ST_DONE;
              port_done[pick_idx] <= 1'b1;
            end else if (sel_we) begin
              state            <= ST_WR;
              sdram_wr_req     <= 1'b1;
              sdram_wr_addr    <= sel_addr;
              sdram_wr_bst_len <= sel_len;
            end else begin
              state            <= ST_RD;
              sdram_rd_req     <= 1'b1;
              sdram_rd_addr    <= sel_addr;
              sdram_rd_bst_len <= sel_len;
            end
          end
        end
        ST_WR: begin
          if (sdram_wr_ack) begin
            if (cnt == len_q - 1'b1) begin
              sdram_wr_req      <= 1'b0;
              cnt               <= '0;
              state             <= ST_DONE;
              port_done[winner] <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_RD: begin
          if (sdram_rd_ack) begin
            if (cnt == len_q - 1'b1) begin
              sdram_rd_req      <= 1'b0;
              cnt               <= '0;
              state             <= ST_DONE;
              port_done[winner] <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_DONE: begin
          rr_ptr           <= (winner == IDX_W'(NUM_PORTS - 1)) ? '0 : winner + 1'b1;
          sdram_wr_addr    <= '0;
          sdram_wr_bst_len <= '0;
          sdram_rd_addr    <= '0;
          sdram_rd_bst_len <= '0;
          state            <= ST_ARB;
        end
        default: state <= ST_WAIT_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arb.sv
// Randomized clients and sdram_ctrl stand-in checked against a transaction-level model.
`timescale 1ns/1ps
module tb_sdram_port_arb;

  localparam int NP = 3;
  localparam int AW = 24;
  localparam int DW = 16;
  localparam int LW = 10;

  logic clk = 1'b0;
  logic rst_n, init_end;
  logic [NP-1:0]    port_req, port_we, port_wr_ack, port_rd_ack, port_done;
  logic [NP*AW-1:0] port_addr;
  logic [NP*LW-1:0] port_bst_len;
  logic [NP*DW-1:0] port_wr_data;
  logic [DW-1:0]    port_rd_data;
  logic             sdram_wr_req, sdram_rd_req, sdram_wr_ack, sdram_rd_ack;
  logic [AW-1:0]    sdram_wr_addr, sdram_rd_addr;
  logic [LW-1:0]    sdram_wr_bst_len, sdram_rd_bst_len;
  logic [DW-1:0]    sdram_wr_data, sdram_rd_data;

  always #5 clk = ~clk;

  sdram_port_arb #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .sdram_clk(clk), .sdram_rst_n(rst_n), .sdram_init_end(init_end),
    .port_req(port_req), .port_we(port_we), .port_addr(port_addr),
    .port_bst_len(port_bst_len), .port_wr_data(port_wr_data),
    .port_wr_ack(port_wr_ack), .port_rd_ack(port_rd_ack), .port_rd_data(port_rd_data),
    .port_done(port_done),
    .sdram_wr_req(sdram_wr_req), .sdram_rd_req(sdram_rd_req),
    .sdram_wr_addr(sdram_wr_addr), .sdram_rd_addr(sdram_rd_addr),
    .sdram_wr_bst_len(sdram_wr_bst_len), .sdram_rd_bst_len(sdram_rd_bst_len),
    .sdram_wr_data(sdram_wr_data), .sdram_wr_ack(sdram_wr_ack),
    .sdram_rd_ack(sdram_rd_ack), .sdram_rd_data(sdram_rd_data)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Client jobs and sdram_ctrl-side burst model.
  bit              active[NP], jwe[NP], granted[NP], release_q[NP];
  logic [AW-1:0]   jaddr[NP];
  logic [LW-1:0]   jlen[NP];
  logic [DW-1:0]   jbase[NP];
  int              wcnt[NP], rcnt[NP], idle_wait[NP];
  bit              busy, sl_we, await_done, first, rand_en, spur;
  int              sl_len, sl_cnt, cur, last_win, done_port, gap, ack_pct;
  logic [NP-1:0]   snap;

  function automatic int rr_expect(input logic [NP-1:0] r, input int last);
    for (int k = 1; k <= NP; k++)
      if (r[(last + k) % NP]) return (last + k) % NP;
    return -1;
  endfunction

  function automatic logic [NP-1:0] onehot(input int i);
    logic [NP-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic bit any_active();
    for (int p = 0; p < NP; p++) if (active[p]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    busy = 0; await_done = 0; first = 1; last_win = NP - 1; gap = 0; cur = 0; done_port = 0;
    sl_len = 0; sl_cnt = 0; sl_we = 0;
    for (int p = 0; p < NP; p++) begin
      active[p] = 0; granted[p] = 0; release_q[p] = 0;
      wcnt[p] = 0; rcnt[p] = 0; idle_wait[p] = 0;
      jwe[p] = 0; jaddr[p] = '0; jlen[p] = '0; jbase[p] = '0;
    end
  endtask

  task automatic start_job(input int p, input bit we, input int len);
    active[p] = 1; granted[p] = 0; jwe[p] = we; wcnt[p] = 0; rcnt[p] = 0;
    jaddr[p] = AW'($urandom); jlen[p] = LW'(len); jbase[p] = DW'($urandom);
    port_req[p] = 1'b1;
    port_we[p]  = we;
    port_addr[p*AW +: AW]    = jaddr[p];
    port_bst_len[p*LW +: LW] = jlen[p];
  endtask

  task automatic finish_job(input int p);
    check("done_active", active[p], 1'b1);
    check("ack_count", jwe[p] ? wcnt[p] : rcnt[p], jlen[p]);
    check("wrong_dir_acks", jwe[p] ? rcnt[p] : wcnt[p], 0);
    active[p] = 0;
    release_q[p] = 1;
  endtask

  task automatic cycle();
    int w;
    logic [NP-1:0] ewa, era;
    @(negedge clk);
    snap = port_req;
    if (!busy && (sdram_wr_req || sdram_rd_req)) begin
      w = rr_expect(snap, last_win);
      check("grant_exists", (w >= 0), 1'b1);
      if (w < 0) w = 0;
      cur = w; last_win = w;
      check("grant_active", active[w], 1'b1);
      check("grant_dir", {sdram_wr_req, sdram_rd_req}, jwe[w] ? 2'b10 : 2'b01);
      check("grant_nonzero_len", (jlen[w] != '0), 1'b1);
      if (!first) check("idle_gap", (gap >= 2), 1'b1);
      busy = 1; sl_we = sdram_wr_req; sl_len = int'(jlen[w]); sl_cnt = 0; granted[w] = 1;
      port_addr[w*AW +: AW]    = AW'($urandom);
      port_bst_len[w*LW +: LW] = LW'($urandom);
      port_we[w]               = ~port_we[w];
    end
    for (int p = 0; p < NP; p++) begin
      if (release_q[p]) begin
        port_req[p] = 1'b0; release_q[p] = 0; idle_wait[p] = $urandom_range(0, 4);
      end else if (rand_en && !active[p]) begin
        if (idle_wait[p] > 0) idle_wait[p]--;
        else if ($urandom_range(0, 2) == 0)
          start_job(p, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 6) == 0) ? 0 : int'($urandom_range(1, 8)));
      end
      port_wr_data[p*DW +: DW] = (active[p] && granted[p] && jwe[p]) ? DW'(jbase[p] + wcnt[p])
                                                                    : DW'($urandom);
    end
    sdram_wr_ack = 0; sdram_rd_ack = 0; sdram_rd_data = DW'($urandom);
    if (busy) begin
      if ($urandom_range(0, 99) < ack_pct) begin
        if (sl_we) sdram_wr_ack = 1; else sdram_rd_ack = 1;
      end
      if (spur && $urandom_range(0, 7) == 0) begin
        if (sl_we) sdram_rd_ack = 1; else sdram_wr_ack = 1;
      end
    end else if (spur) begin
      sdram_wr_ack = ($urandom_range(0, 3) == 0);
      sdram_rd_ack = ($urandom_range(0, 3) == 0);
    end

    #4;
    ewa = '0; era = '0;
    if (busy && sl_we && sdram_wr_ack) ewa[cur] = 1'b1;
    if (busy && !sl_we && sdram_rd_ack) era[cur] = 1'b1;
    check("port_wr_ack", port_wr_ack, ewa);
    check("port_rd_ack", port_rd_ack, era);
    if (busy) begin
      if (sl_we) begin
        check("wr_addr", sdram_wr_addr, jaddr[cur]);
        check("wr_len", sdram_wr_bst_len, jlen[cur]);
        check("rd_side_zero", {sdram_rd_req, sdram_rd_addr, sdram_rd_bst_len}, 0);
        if (sdram_wr_ack) check("wr_data", sdram_wr_data, DW'(jbase[cur] + sl_cnt));
      end else begin
        check("rd_addr", sdram_rd_addr, jaddr[cur]);
        check("rd_len", sdram_rd_bst_len, jlen[cur]);
        check("wr_side_zero", {sdram_wr_req, sdram_wr_addr, sdram_wr_bst_len}, 0);
        if (sdram_rd_ack) check("rd_data", port_rd_data, sdram_rd_data);
      end
      check("req_held", sl_we ? sdram_wr_req : sdram_rd_req, 1'b1);
    end else begin
      check("req_idle", {sdram_wr_req, sdram_rd_req}, 2'b00);
    end
    for (int p = 0; p < NP; p++) begin
      if (port_wr_ack[p]) wcnt[p]++;
      if (port_rd_ack[p]) rcnt[p]++;
    end
    if (await_done) begin
      check("done_pulse", port_done, onehot(done_port));
      finish_job(done_port);
      await_done = 0;
    end else if (port_done != '0) begin
      w = rr_expect(snap, last_win);
      check("zero_len_done", port_done, (w >= 0) ? onehot(w) : '0);
      if (w >= 0) begin
        check("zero_len_job", jlen[w], 0);
        last_win = w;
        finish_job(w);
      end
    end
    if (busy && ((sl_we && sdram_wr_ack) || (!sl_we && sdram_rd_ack))) sl_cnt++;
    if (busy && sl_cnt == sl_len) begin
      busy = 0; await_done = 1; done_port = cur; gap = 0; first = 0;
    end else if (!busy) begin
      gap++;
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int k;
    k = 0;
    rand_en = 0;
    while ((busy || await_done || any_active()) && k < budget) begin
      cycle();
      k++;
    end
    check(tag, (busy || await_done || any_active()), 1'b0);
    repeat (2) cycle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    rst_n = 0; init_end = 0;
    port_req = '0; port_we = '0; port_addr = '0; port_bst_len = '0; port_wr_data = '0;
    sdram_wr_ack = 0; sdram_rd_ack = 0; sdram_rd_data = '0;
    model_reset();
    ack_pct = 70; spur = 1; rand_en = 0;
    repeat (3) @(negedge clk);
    check("rst_reqs", {sdram_wr_req, sdram_rd_req}, 0);
    check("rst_done", port_done, 0);
    check("rst_acks", {port_wr_ack, port_rd_ack}, 0);
    check("rst_addr", {sdram_wr_addr, sdram_rd_addr}, 0);
    check("rst_len", {sdram_wr_bst_len, sdram_rd_bst_len}, 0);
    rst_n = 1;

    // Requests pending before init completes; port 0 must win first.
    start_job(0, 1'b1, 4);
    start_job(1, 1'b0, 3);
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("init_hold", {sdram_wr_req, sdram_rd_req}, 0);
    end
    @(negedge clk);
    #1 init_end = 1;
    k = 0;
    while (!busy && k < 4) begin
      cycle();
      k++;
    end
    check("init_grant", busy, 1'b1);
    check("init_first_port", cur, 0);
    drain("drain_initial", 200);

    // init_end dropping after start-up must not matter.
    @(negedge clk);
    #1 init_end = 0;
    rand_en = 1;
    for (int i = 0; i < 3000; i++) cycle();
    drain("drain_random", 800);
    @(negedge clk);
    #1 init_end = 1;

    // Reset in the middle of a 10-word write.
    ack_pct = 100; spur = 0;
    start_job(0, 1'b1, 10);
    k = 0;
    while (wcnt[0] < 5 && k < 40) begin
      cycle();
      k++;
    end
    check("rst_mid_reached", wcnt[0], 5);
    @(negedge clk);
    #1 rst_n = 0;
    #1;
    check("rst_mid_req", sdram_wr_req, 1'b0);
    check("rst_mid_ack", port_wr_ack, 0);
    check("rst_mid_done", port_done, 0);
    model_reset();
    port_req = '0; sdram_wr_ack = 0; sdram_rd_ack = 0;
    repeat (3) begin
      @(negedge clk);
      check("rst_hold_done", port_done, 0);
      check("rst_hold_req", {sdram_wr_req, sdram_rd_req}, 0);
    end
    rst_n = 1;
    start_job(0, 1'b1, 3);
    k = 0;
    while (active[0] && k < 60) begin
      cycle();
      k++;
    end
    check("post_rst_done", active[0], 1'b0);
    drain("drain_final", 100);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
